// File: rtl/mem_access_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_access_stage                                                           |
// | Load/store unit between execute and write-back over a valid/ack dmem bus.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mem_access_stage #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 5
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        valid_i,
   input  logic        MemRead_i,
   input  logic        MemWrite_i,
   input  logic [2:0]  funct3_i,
   input  logic [31:0] ALUOut,
   input  logic [31:0] DataOutReg2,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic [31:0] ReadData,
   output logic        done_o,
   output logic        fault_o,
   output logic        stall_o
);

   localparam logic [1:0] c_IDLE  = 2'd0;
   localparam logic [1:0] c_BUSY  = 2'd1;
   localparam logic [1:0] c_DONE  = 2'd2;
   localparam logic [1:0] c_FAULT = 2'd3;

   localparam logic [CNT_W-1:0] c_TMO    = CNT_W'(TIMEOUT);
   localparam bit               c_TMO_EN = (TIMEOUT != 0);

   logic [1:0]       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [1:0]       r_off;
   logic [2:0]       r_f3;

   logic             w_accept;
   logic             w_bad_f3;
   logic             w_misal;
   logic             w_reject;
   logic [3:0]       w_be;
   logic [31:0]      w_wdata;
   logic [31:0]      w_lane;
   logic [31:0]      w_ext;
   logic [CNT_W-1:0] w_cnt_nxt;

   // Request decode: legality, alignment and lane placement of the store data.
   always_comb begin
      w_accept = (r_state == c_IDLE) && valid_i && (MemRead_i || MemWrite_i);
      if (MemWrite_i)
         w_bad_f3 = funct3_i[2] || (funct3_i[1:0] == 2'b11);
      else
         w_bad_f3 = (funct3_i[1:0] == 2'b11) || (funct3_i[2] && funct3_i[1]);
      w_misal  = ((funct3_i[1:0] == 2'b01) && ALUOut[0]) ||
                 ((funct3_i[1:0] == 2'b10) && (ALUOut[1:0] != 2'b00));
      w_reject = (MemRead_i && MemWrite_i) || w_bad_f3 || w_misal;
      case (funct3_i[1:0])
         2'b00: begin
            w_be    = 4'b0001 << ALUOut[1:0];
            w_wdata = {4{DataOutReg2[7:0]}};
         end
         2'b01: begin
            w_be    = ALUOut[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{DataOutReg2[15:0]}};
         end
         default: begin
            w_be    = 4'b1111;
            w_wdata = DataOutReg2;
         end
      endcase
   end

   // Bring the addressed lane down to bit 0, then extend per the latched funct3.
   always_comb begin
      w_lane = dmem_rdata >> {r_off, 3'b000};
      case (r_f3)
         3'b000:  w_ext = {{24{w_lane[7]}}, w_lane[7:0]};
         3'b001:  w_ext = {{16{w_lane[15]}}, w_lane[15:0]};
         3'b100:  w_ext = {24'd0, w_lane[7:0]};
         3'b101:  w_ext = {16'd0, w_lane[15:0]};
         default: w_ext = w_lane;
      endcase
   end

   assign w_cnt_nxt = r_cnt + CNT_W'(1);
   assign stall_o   = w_accept || (r_state == c_BUSY);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= c_IDLE;
         r_cnt      <= '0;
         r_off      <= 2'd0;
         r_f3       <= 3'd0;
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         dmem_addr  <= 32'd0;
         dmem_be    <= 4'd0;
         dmem_wdata <= 32'd0;
         ReadData   <= 32'd0;
         done_o     <= 1'b0;
         fault_o    <= 1'b0;
      end else begin
         done_o  <= 1'b0;
         fault_o <= 1'b0;
         case (r_state)
            c_IDLE: begin
               if (w_accept) begin
                  if (w_reject) begin
                     fault_o <= 1'b1;
                     r_state <= c_FAULT;
                  end else begin
                     r_off      <= ALUOut[1:0];
                     r_f3       <= funct3_i;
                     r_cnt      <= '0;
                     dmem_req   <= 1'b1;
                     dmem_we    <= MemWrite_i;
                     dmem_addr  <= {ALUOut[31:2], 2'b00};
                     dmem_be    <= w_be;
                     dmem_wdata <= w_wdata;
                     r_state    <= c_BUSY;
                  end
               end
            end
            c_BUSY: begin
               // An ack arriving on the final allowed cycle still completes.
               if (dmem_ack) begin
                  dmem_req <= 1'b0;
                  if (!dmem_we)
                     ReadData <= w_ext;
                  done_o  <= 1'b1;
                  r_state <= c_DONE;
               end else if (c_TMO_EN && (w_cnt_nxt == c_TMO)) begin
                  dmem_req <= 1'b0;
                  fault_o  <= 1'b1;
                  r_state  <= c_FAULT;
               end else begin
                  r_cnt <= w_cnt_nxt;
               end
            end
            default: r_state <= c_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// Testbench for mem_access_stage: directed plan scenarios plus randomized
// accesses compared against an arithmetic reference model.
module tb_mem_access_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        valid_i = 1'b0, MemRead_i = 1'b0, MemWrite_i = 1'b0;
   logic [2:0]  funct3_i = 3'd0;
   logic [31:0] ALUOut = 32'd0, DataOutReg2 = 32'd0;
   logic        dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata;
   logic [3:0]  dmem_be;
   logic        dmem_ack = 1'b0;
   logic [31:0] dmem_rdata = 32'd0;
   logic [31:0] ReadData;
   logic        done_o, fault_o, stall_o;

   int n_vec = 0;
   int n_err = 0;
   logic [31:0] model_rd = 32'd0;

   // observations from the last access
   int          ob_req, ob_stall, ob_lat, ob_done, ob_fault, ob_hold;
   logic [31:0] ob_addr, ob_wd, ob_rd;
   logic [3:0]  ob_be;
   logic        ob_we;

   always #5 clk = ~clk;

   mem_access_stage #(.TIMEOUT(4), .CNT_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .MemRead_i(MemRead_i),
      .MemWrite_i(MemWrite_i), .funct3_i(funct3_i), .ALUOut(ALUOut),
      .DataOutReg2(DataOutReg2), .dmem_req(dmem_req), .dmem_we(dmem_we),
      .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
      .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .ReadData(ReadData),
      .done_o(done_o), .fault_o(fault_o), .stall_o(stall_o)
   );

   // Reference: what the bus and write-back should see for one access.
   function automatic void model(input logic rd, input logic wr, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wd,
                                 input logic [31:0] rdat, input logic [31:0] prev,
                                 output logic flt, output logic [3:0] be,
                                 output logic [31:0] eaddr, output logic [31:0] ewd,
                                 output logic [31:0] erd);
      int nb, off;
      longint mask, v;
      nb  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      off = int'(addr[1:0]);
      flt = (rd && wr) ||
            (rd && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) ||
            (wr && (f3 > 3'd2)) || ((off % nb) != 0);
      mask  = (64'sd1 <<< (8 * nb)) - 1;
      be    = 4'(((1 << nb) - 1) << off);
      eaddr = addr & ~32'd3;
      ewd   = 32'd0;
      for (int k = 0; k < 4 / nb; k++)
         ewd |= 32'((longint'(wd) & mask) << (8 * nb * k));
      v = (longint'(rdat) >> (8 * off)) & mask;
      if (!f3[2] && nb < 4 && v[8*nb-1]) v |= ~mask;
      erd = wr ? prev : v[31:0];
   endfunction

   // Drive one access starting in an IDLE cycle; ack arrives in BUSY cycle ack_dly (-1 never).
   task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input int ack_dly, input logic [31:0] rdat);
      int end_c;
      ob_req = 0; ob_stall = 0; ob_done = 0; ob_fault = 0; ob_hold = 0;
      ob_addr = 0; ob_wd = 0; ob_be = 0; ob_we = 0; ob_rd = 0;
      valid_i = 1'b1; MemRead_i = rd; MemWrite_i = wr; funct3_i = f3;
      ALUOut = addr; DataOutReg2 = wd;
      #1; if (stall_o) ob_stall++;
      @(posedge clk); #1;
      valid_i = 1'b0; MemRead_i = 1'($urandom); MemWrite_i = 1'($urandom);
      funct3_i = 3'($urandom); ALUOut = $urandom; DataOutReg2 = $urandom;
      end_c = -1;
      for (int c = 1; c < 60; c++) begin
         if (dmem_req) begin
            if (ob_req == 0) begin
               ob_addr = dmem_addr; ob_be = dmem_be; ob_wd = dmem_wdata; ob_we = dmem_we;
            end else if (dmem_addr !== ob_addr || dmem_be !== ob_be ||
                         dmem_wdata !== ob_wd || dmem_we !== ob_we) begin
               ob_hold++;
            end
            dmem_ack = (ack_dly >= 0) && (ob_req == ack_dly);
            ob_req++;
         end else begin
            dmem_ack = 1'($urandom);
         end
         dmem_rdata = (dmem_ack && dmem_req) ? rdat : $urandom;
         #1;
         if (stall_o) ob_stall++;
         if (done_o) begin ob_done++; if (end_c < 0) begin end_c = c; ob_rd = ReadData; end end
         if (fault_o) begin ob_fault++; if (end_c < 0) end_c = c; end
         @(posedge clk); #1;
         dmem_ack = 1'b0;
         if (end_c >= 0 && c >= end_c + 1) break;
      end
      ob_lat = end_c;
   endtask

   task automatic test_reset;
      repeat (2) @(posedge clk);
      #1;
      if ({dmem_req, dmem_we, dmem_be, done_o, fault_o, stall_o} !== 9'd0 ||
          dmem_addr !== 32'd0 || dmem_wdata !== 32'd0 || ReadData !== 32'd0) begin
         n_err++; $display("FAIL reset outputs: req=%b addr=%h be=%b wd=%h rd=%h done=%b fault=%b stall=%b, want all 0",
                           dmem_req, dmem_addr, dmem_be, dmem_wdata, ReadData, done_o, fault_o, stall_o);
      end
      n_vec++;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_load_word;
      run_access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 1, 32'hDEADBEEF);
      model_rd = 32'hDEADBEEF;
      if (ob_addr !== 32'h100 || ob_be !== 4'b1111 || ob_we !== 1'b0) begin
         n_err++; $display("FAIL lw bus: addr=%h be=%b we=%b want 00000100 1111 0", ob_addr, ob_be, ob_we);
      end
      n_vec++;
      if (ob_stall !== 3 || ob_done !== 1 || ob_lat !== 3 || ob_hold !== 0) begin
         n_err++; $display("FAIL lw timing: stall=%0d done=%0d lat=%0d hold=%0d want 3 1 3 0",
                           ob_stall, ob_done, ob_lat, ob_hold);
      end
      n_vec++;
      if (ob_rd !== model_rd) begin
         n_err++; $display("FAIL lw data: got %h want %h", ob_rd, model_rd);
      end
      n_vec++;
   endtask

   task automatic test_load_bytes;
      run_access(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 0, 32'h80FF0000);
      if (ob_be !== 4'b1000 || ob_rd !== 32'hFFFFFF80) begin
         n_err++; $display("FAIL lb: be=%b rd=%h want 1000 ffffff80", ob_be, ob_rd);
      end
      n_vec++;
      run_access(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 2, 32'h80FF0000);
      if (ob_rd !== 32'h00000080 || ob_lat !== 4) begin
         n_err++; $display("FAIL lbu: rd=%h lat=%0d want 00000080 4", ob_rd, ob_lat);
      end
      n_vec++;
      run_access(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 0, 32'h80FF0000);
      model_rd = 32'hFFFF80FF;
      if (ob_be !== 4'b1100 || ob_rd !== model_rd) begin
         n_err++; $display("FAIL lh: be=%b rd=%h want 1100 %h", ob_be, ob_rd, model_rd);
      end
      n_vec++;
   endtask

   task automatic test_stores;
      run_access(1'b0, 1'b1, 3'b000, 32'h201, 32'h12345678, 0, 32'h0);
      if (ob_addr !== 32'h200 || ob_be !== 4'b0010 || ob_wd !== 32'h78787878 || ob_we !== 1'b1) begin
         n_err++; $display("FAIL sb bus: addr=%h be=%b wd=%h we=%b want 00000200 0010 78787878 1",
                           ob_addr, ob_be, ob_wd, ob_we);
      end
      n_vec++;
      if (ob_lat !== 2 || ob_done !== 1) begin
         n_err++; $display("FAIL sb latency: lat=%0d done=%0d want 2 1", ob_lat, ob_done);
      end
      n_vec++;
      run_access(1'b0, 1'b1, 3'b001, 32'h202, 32'h12345678, 0, 32'h0);
      if (ob_be !== 4'b1100 || ob_wd !== 32'h56785678 || ob_rd !== model_rd) begin
         n_err++; $display("FAIL sh: be=%b wd=%h rd=%h want 1100 56785678 %h", ob_be, ob_wd, ob_rd, model_rd);
      end
      n_vec++;
   endtask

   task automatic test_faults;
      logic [2:0] f3s [3] = '{3'b010, 3'b011, 3'b010};
      logic [31:0] ads [3] = '{32'h102, 32'h100, 32'h100};
      logic [1:0]  kinds [3] = '{2'b10, 2'b10, 2'b11};
      for (int i = 0; i < 3; i++) begin
         run_access(kinds[i][1], kinds[i][0], f3s[i], ads[i], 32'h0, 0, 32'h0);
         if (ob_fault !== 1 || ob_lat !== 1 || ob_req !== 0 || ob_done !== 0 ||
             ob_stall !== 1 || ReadData !== model_rd) begin
            n_err++; $display("FAIL fault case %0d: fault=%0d lat=%0d req=%0d done=%0d stall=%0d rd=%h want 1 1 0 0 1 %h",
                              i, ob_fault, ob_lat, ob_req, ob_done, ob_stall, ReadData, model_rd);
         end
         n_vec++;
      end
   endtask

   task automatic test_timeout;
      run_access(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, -1, 32'h0);
      if (ob_req !== 4 || ob_fault !== 1 || ob_lat !== 5 || ob_done !== 0 || ob_stall !== 5) begin
         n_err++; $display("FAIL timeout: req=%0d fault=%0d lat=%0d done=%0d stall=%0d want 4 1 5 0 5",
                           ob_req, ob_fault, ob_lat, ob_done, ob_stall);
      end
      n_vec++;
      run_access(1'b1, 1'b0, 3'b010, 32'h404, 32'h0, 3, 32'hCAFE0001);
      model_rd = 32'hCAFE0001;
      if (ob_done !== 1 || ob_fault !== 0 || ob_rd !== model_rd) begin
         n_err++; $display("FAIL after timeout: done=%0d fault=%0d rd=%h want 1 0 %h",
                           ob_done, ob_fault, ob_rd, model_rd);
      end
      n_vec++;
   endtask

   task automatic test_reset_midop;
      int bad;
      valid_i = 1'b1; MemRead_i = 1'b1; MemWrite_i = 1'b0; funct3_i = 3'b010; ALUOut = 32'h300;
      @(posedge clk); #1;
      valid_i = 1'b0; MemRead_i = 1'b0;
      @(posedge clk); #1;
      if (dmem_req !== 1'b1) begin
         n_err++; $display("FAIL midop busy: req=%b want 1", dmem_req);
      end
      n_vec++;
      #2 rst_n = 1'b0;
      #1;
      model_rd = 32'd0;
      if (dmem_req !== 1'b0 || done_o !== 1'b0 || fault_o !== 1'b0 || ReadData !== model_rd) begin
         n_err++; $display("FAIL async reset: req=%b done=%b fault=%b rd=%h want 0 0 0 0",
                           dmem_req, done_o, fault_o, ReadData);
      end
      n_vec++;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      bad = 0;
      repeat (3) begin
         @(posedge clk); #1;
         if (done_o || fault_o || dmem_req) bad++;
      end
      if (bad !== 0) begin
         n_err++; $display("FAIL post reset quiet: %0d active cycles want 0", bad);
      end
      n_vec++;
      run_access(1'b1, 1'b0, 3'b010, 32'h104, 32'h0, 1, 32'h13579BDF);
      model_rd = 32'h13579BDF;
      if (ob_done !== 1 || ob_rd !== model_rd || ob_addr !== 32'h104) begin
         n_err++; $display("FAIL lw after reset: done=%0d rd=%h addr=%h want 1 %h 00000104",
                           ob_done, ob_rd, ob_addr, model_rd);
      end
      n_vec++;
   endtask

   task automatic test_random;
      logic rd, wr, flt;
      logic [2:0] f3;
      logic [31:0] addr, wd, rdat, eaddr, ewd, erd;
      logic [3:0] be;
      int dly, kind;
      for (int i = 0; i < 60; i++) begin
         kind = $urandom_range(0, 7);
         rd = (kind != 1) && (kind != 2);
         wr = (kind == 1) || (kind == 2) || (kind == 7);
         f3 = 3'($urandom);
         addr = $urandom; wd = $urandom; rdat = $urandom;
         dly = $urandom_range(0, 2);
         model(rd, wr, f3, addr, wd, rdat, model_rd, flt, be, eaddr, ewd, erd);
         run_access(rd, wr, f3, addr, wd, dly, rdat);
         if (flt) begin
            if (ob_fault !== 1 || ob_req !== 0 || ob_done !== 0 || ob_lat !== 1) begin
               n_err++; $display("FAIL rand %0d fault: fault=%0d req=%0d done=%0d lat=%0d want 1 0 0 1",
                                 i, ob_fault, ob_req, ob_done, ob_lat);
            end
            n_vec++;
         end else begin
            if (ob_addr !== eaddr || ob_be !== be || ob_we !== wr ||
                (wr && ob_wd !== ewd) || ob_hold !== 0) begin
               n_err++; $display("FAIL rand %0d bus: addr=%h be=%b we=%b wd=%h hold=%0d want %h %b %b %h 0",
                                 i, ob_addr, ob_be, ob_we, ob_wd, ob_hold, eaddr, be, wr, ewd);
            end
            n_vec++;
            if (ob_done !== 1 || ob_fault !== 0 || ob_lat !== dly + 2 || ob_rd !== erd) begin
               n_err++; $display("FAIL rand %0d result: done=%0d fault=%0d lat=%0d rd=%h want 1 0 %0d %h",
                                 i, ob_done, ob_fault, ob_lat, ob_rd, dly + 2, erd);
            end
            n_vec++;
            model_rd = erd;
         end
      end
   endtask

   initial begin
      test_reset();
      test_load_word();
      test_load_bytes();
      test_stores();
      test_faults();
      test_timeout();
      test_reset_midop();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory-access stage directly downstream of the execute stage. Consumes the ALU result as the effective address and the rs2 operand as store data.
- Performs byte, half and word loads and stores over a valid/ack data-memory bus. Holds the datapath with a stall while a transfer is pending.
- Returns sign- or zero-extended load data to write-back. Flags misaligned, illegal and timed-out accesses.

Parameters:
- TIMEOUT, 16, number of BUSY cycles to wait for dmem_ack before faulting; 0 disables the timeout.
- CNT_W, 5, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- valid_i  input  1  execute stage presents an instruction this cycle.
- MemRead_i  input  1  instruction is a load.
- MemWrite_i  input  1  instruction is a store.
- funct3_i  input  3  access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- ALUOut  input  32  effective address from the execute stage.
- DataOutReg2  input  32  store data (rs2).
- dmem_req  output  1  bus request, registered.
- dmem_we  output  1  1 = write, registered.
- dmem_addr  output  32  word address {addr[31:2],2'b00}, registered.
- dmem_be  output  4  byte enables, registered.
- dmem_wdata  output  32  lane-replicated store data, registered.
- dmem_ack  input  1  bus completes the access this cycle.
- dmem_rdata  input  32  read word, valid when dmem_ack=1.
- ReadData  output  32  extended load result, registered.
- done_o  output  1  one-cycle pulse: access finished.
- fault_o  output  1  one-cycle pulse: access aborted.
- stall_o  output  1  hold upstream pipeline, combinational.

Behaviour:
- Reset: asynchronous on rst_n=0.
  - All registered outputs go to 0 (dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, ReadData, done_o, fault_o); state returns to IDLE; timeout counter clears.
  - A reset mid-transfer drops dmem_req immediately. No done_o or fault_o is produced for the aborted access.
- FSM states: IDLE, BUSY, DONE, FAULT.
- IDLE:
  - Accept condition: valid_i=1 and MemRead_i|MemWrite_i=1.
  - Fault conditions, checked on accept; any one sends the FSM to FAULT:
    - MemRead_i and MemWrite_i both 1.
    - Illegal funct3: loads allow only 000/001/010/100/101; stores allow only 000/001/010.
    - Misaligned address: half with addr[0]=1; word with addr[1:0]≠0.
  - Otherwise latch address, byte enables, store data and funct3; set dmem_req=1; go to BUSY.
  - valid_i with neither MemRead_i nor MemWrite_i: no action, no stall.
- Byte enables and store data:
  - Byte: be = 4'b0001 << addr[1:0]; wdata = {4{rs2[7:0]}}.
  - Half: be = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{rs2[15:0]}}.
  - Word: be = 4'b1111; wdata = rs2.
  - Loads drive the same be; dmem_we=0.
- BUSY:
  - All dmem_* outputs are held stable until ack.
  - On dmem_ack=1: extract the lane selected by the latched addr[1:0] from dmem_rdata, sign- or zero-extend per funct3, register it into ReadData (loads only; stores leave ReadData unchanged), drop dmem_req, go to DONE.
  - Timeout: the counter increments on each BUSY cycle without ack. If TIMEOUT≠0 and the count reaches TIMEOUT, drop dmem_req and go to FAULT.
  - An ack in the same cycle the count would reach TIMEOUT wins: go to DONE.
- DONE: done_o=1 for exactly one cycle, then IDLE. ReadData holds its value until the next load completes.
- FAULT: fault_o=1 for exactly one cycle, then IDLE. ReadData unchanged; no bus access was issued, or the issued one was abandoned.
- stall_o = (IDLE & accepting) | BUSY. It is 0 in DONE and FAULT, so upstream advances in the done/fault cycle.
- valid_i is ignored outside IDLE. dmem_ack is ignored outside BUSY.
- Minimum latency: accept at cycle N; dmem_req high in N+1; ack in N+1 gives done_o and valid ReadData in N+2.

Test Plan:
- Load word: ALUOut=0x100, funct3=010; ack two cycles after req with rdata=0xDEADBEEF -> dmem_addr=0x100, be=1111; stall_o high 3 cycles; done_o pulse; ReadData=0xDEADBEEF.
- Load bytes at ALUOut=0x103, rdata=0x80FF_0000:
  - lb -> be=1000, ReadData=0xFFFFFF80.
  - lbu -> ReadData=0x00000080.
  - lh at ALUOut=0x102 -> be=1100, ReadData=0xFFFF80FF.
- Stores, rs2=0x12345678:
  - sb at 0x201 -> dmem_addr=0x200, be=0010, wdata=0x78787878, we=1.
  - sh at 0x202 -> be=1100, wdata=0x56785678.
  - Ack in first BUSY cycle -> done_o exactly 2 cycles after accept.
- Faults:
  - lw at 0x102 -> fault_o one cycle after accept; dmem_req never asserted.
  - funct3=011 load -> fault.
  - MemRead_i=MemWrite_i=1 -> fault.
- Timeout: TIMEOUT=4, ack never given -> dmem_req high exactly 4 cycles, then fault_o pulse, stall_o low, FSM back in IDLE accepting the next access.
- Reset mid-op: rst_n low while BUSY -> dmem_req=0 asynchronously, no done_o/fault_o; after release, a new lw completes normally.
